// File: rtl/fetch_sequencer.sv
// fetch_sequencer: sequenced instruction fetch with PC ownership, one outstanding request,
// single-entry decode output register and branch redirect/squash.  Rev 1.0
`default_nettype none

module fetch_sequencer #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             branch,
  input  logic [XLEN-1:0]  target_PC,
  output logic             imem_req_valid,
  output logic [XLEN-1:0]  imem_req_addr,
  input  logic             imem_req_ready,
  input  logic             imem_resp_valid,
  input  logic [XLEN-1:0]  imem_resp_data,
  output logic             inst_valid,
  output logic [XLEN-1:0]  inst_data,
  output logic [XLEN-1:0]  inst_PC,
  input  logic             inst_ready,
  output logic [XLEN-1:0]  PC,
  output logic [CNT_W-1:0] squash_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_FULL = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  req_pc_q, req_pc_d;
  logic             inst_valid_q, inst_valid_d;
  logic [XLEN-1:0]  inst_data_q, inst_data_d;
  logic [XLEN-1:0]  inst_pc_q, inst_pc_d;
  logic             squash_q, squash_d;
  logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;

  logic             req_hs;
  logic             resp_hit;
  logic [CNT_W-1:0] squash_cnt_inc;
  logic [1:0]       unused_target_lsb;

  assign unused_target_lsb = target_PC[1:0];

  assign req_hs   = (state_q == S_REQ) && imem_req_ready;
  assign resp_hit = (state_q == S_WAIT) && imem_resp_valid;
  assign squash_cnt_inc = (&squash_cnt_q) ? squash_cnt_q : squash_cnt_q + 1'b1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      req_pc_q     <= '0;
      inst_valid_q <= 1'b0;
      inst_data_q  <= '0;
      inst_pc_q    <= '0;
      squash_q     <= 1'b0;
      squash_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      inst_valid_q <= inst_valid_d;
      inst_data_q  <= inst_data_d;
      inst_pc_q    <= inst_pc_d;
      squash_q     <= squash_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    inst_valid_d = inst_valid_q;
    inst_data_d  = inst_data_q;
    inst_pc_d    = inst_pc_q;
    squash_d     = squash_q;
    squash_cnt_d = squash_cnt_q;

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (req_hs) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + XLEN'(4);
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (resp_hit) begin
          if (squash_q) begin
            squash_d     = 1'b0;
            squash_cnt_d = squash_cnt_inc;
            state_d      = S_REQ;
          end else begin
            inst_data_d  = imem_resp_data;
            inst_pc_d    = req_pc_q;
            inst_valid_d = 1'b1;
            state_d      = S_FULL;
          end
        end
      end
      S_FULL: begin
        if (inst_valid_q && inst_ready) begin
          inst_valid_d = 1'b0;
          state_d      = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Redirect overrides everything above, including a same-cycle handshake or response.
    if (branch) begin
      pc_d         = {target_PC[XLEN-1:2], 2'b00};
      inst_valid_d = 1'b0;
      case (state_q)
        S_REQ: begin
          if (req_hs) squash_d = 1'b1;
        end
        S_WAIT: begin
          if (resp_hit) begin
            inst_data_d  = inst_data_q;
            inst_pc_d    = inst_pc_q;
            squash_d     = 1'b0;
            squash_cnt_d = squash_cnt_inc;
            state_d      = S_REQ;
          end else begin
            squash_d = 1'b1;
          end
        end
        S_FULL: begin
          inst_data_d = inst_data_q;
          inst_pc_d   = inst_pc_q;
          state_d     = S_REQ;
        end
        default: ;
      endcase
    end
  end

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = pc_q;
  assign PC             = pc_q;
  assign inst_valid     = inst_valid_q;
  assign inst_data      = inst_data_q;
  assign inst_PC        = inst_pc_q;
  assign squash_count   = squash_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: table-driven directed bench for fetch_sequencer.  Rev 1.0
`default_nettype none

module tb_fetch_sequencer;

  localparam int TB_CNT_W = 2;

  logic        clock;
  logic        reset;
  logic        branch;
  logic [31:0] target_PC;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_PC;
  logic        inst_ready;
  logic [31:0] PC;
  logic [TB_CNT_W-1:0] squash_count;

  int errors = 0;
  int checks = 0;

  fetch_sequencer #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000),
    .CNT_W    (TB_CNT_W)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .branch          (branch),
    .target_PC       (target_PC),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_data       (inst_data),
    .inst_PC         (inst_PC),
    .inst_ready      (inst_ready),
    .PC              (PC),
    .squash_count    (squash_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        br;
    logic [31:0] tgt;
    logic        rdy;
    logic        rsv;
    logic [31:0] rdata;
    logic        irdy;
    logic        e_rv;
    logic        e_iv;
    logic [31:0] e_data;
    logic [31:0] e_ipc;
    logic [31:0] e_pc;
    logic [TB_CNT_W-1:0] e_sc;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic br, input logic [31:0] tgt, input logic rdy,
                              input logic rsv, input logic [31:0] rdata, input logic irdy,
                              input logic e_rv, input logic e_iv, input logic [31:0] e_data,
                              input logic [31:0] e_ipc, input logic [31:0] e_pc,
                              input logic [TB_CNT_W-1:0] e_sc);
    vec_t v;
    v.br = br; v.tgt = tgt; v.rdy = rdy; v.rsv = rsv; v.rdata = rdata; v.irdy = irdy;
    v.e_rv = e_rv; v.e_iv = e_iv; v.e_data = e_data; v.e_ipc = e_ipc; v.e_pc = e_pc;
    v.e_sc = e_sc;
    return v;
  endfunction

  task automatic check(input vec_t v, input string nm);
    checks++;
    if (imem_req_valid !== v.e_rv || imem_req_addr !== v.e_pc || inst_valid !== v.e_iv ||
        inst_data !== v.e_data || inst_PC !== v.e_ipc || PC !== v.e_pc ||
        squash_count !== v.e_sc) begin
      errors++;
      $display("FAIL %s: got rv=%0b addr=%h iv=%0b data=%h ipc=%h pc=%h sc=%0d; want rv=%0b addr=%h iv=%0b data=%h ipc=%h pc=%h sc=%0d",
               nm, imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_PC, PC,
               squash_count, v.e_rv, v.e_pc, v.e_iv, v.e_data, v.e_ipc, v.e_pc, v.e_sc);
    end
  endtask

  task automatic drive(input vec_t v);
    branch          = v.br;
    target_PC       = v.tgt;
    imem_req_ready  = v.rdy;
    imem_resp_valid = v.rsv;
    imem_resp_data  = v.rdata;
    inst_ready      = v.irdy;
  endtask

  task automatic run(input vec_t v, input string nm);
    drive(v);
    @(posedge clock);
    #1;
    check(v, nm);
  endtask

  initial begin
    vec_t zero;
    zero = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    drive(zero);

    // Straight-line fetch 0x0, 0x4, 0x8 with single-cycle memory
    tv.push_back(mk(0, 0, 1, 0, 0,          1, 1, 0, 0,     0, 32'h0,  0));
    tv.push_back(mk(0, 0, 1, 0, 0,          1, 0, 0, 0,     0, 32'h4,  0));
    tv.push_back(mk(0, 0, 1, 1, 32'hA0,     1, 0, 1, 32'hA0, 0, 32'h4, 0));
    tv.push_back(mk(0, 0, 1, 0, 0,          1, 1, 0, 32'hA0, 0, 32'h4, 0));
    tv.push_back(mk(0, 0, 1, 0, 0,          1, 0, 0, 32'hA0, 0, 32'h8, 0));
    tv.push_back(mk(0, 0, 1, 1, 32'hA4,     1, 0, 1, 32'hA4, 32'h4, 32'h8, 0));
    tv.push_back(mk(0, 0, 1, 0, 0,          1, 1, 0, 32'hA4, 32'h4, 32'h8, 0));
    tv.push_back(mk(0, 0, 1, 0, 0,          1, 0, 0, 32'hA4, 32'h4, 32'hC, 0));
    tv.push_back(mk(0, 0, 1, 1, 32'hA8,     0, 0, 1, 32'hA8, 32'h8, 32'hC, 0));
    // Decode stalls five cycles: nothing moves
    for (int i = 0; i < 5; i++)
      tv.push_back(mk(0, 0, 1, 0, 0,        0, 0, 1, 32'hA8, 32'h8, 32'hC, 0));
    tv.push_back(mk(0, 0, 0, 0, 0,          1, 1, 0, 32'hA8, 32'h8, 32'hC, 0));
    tv.push_back(mk(0, 0, 1, 0, 0,          0, 0, 0, 32'hA8, 32'h8, 32'h10, 0));
    tv.push_back(mk(0, 0, 1, 1, 32'hAC,     0, 0, 1, 32'hAC, 32'hC, 32'h10, 0));
    // Branch in FULL with inst_ready: held 0xC discarded
    tv.push_back(mk(1, 32'h2000, 1, 0, 0,   1, 1, 0, 32'hAC, 32'hC, 32'h2000, 0));
    tv.push_back(mk(0, 0, 0, 0, 0,          0, 1, 0, 32'hAC, 32'hC, 32'h2000, 0));
    tv.push_back(mk(0, 0, 1, 0, 0,          0, 0, 0, 32'hAC, 32'hC, 32'h2004, 0));
    // Branch in WAIT, response two cycles later is squashed
    tv.push_back(mk(1, 32'h1236, 0, 0, 0,   0, 0, 0, 32'hAC, 32'hC, 32'h1234, 0));
    tv.push_back(mk(0, 0, 0, 0, 0,          0, 0, 0, 32'hAC, 32'hC, 32'h1234, 0));
    tv.push_back(mk(0, 0, 1, 1, 32'hDEAD,   0, 1, 0, 32'hAC, 32'hC, 32'h1234, 1));
    tv.push_back(mk(0, 0, 1, 0, 0,          0, 0, 0, 32'hAC, 32'hC, 32'h1238, 1));
    tv.push_back(mk(0, 0, 1, 1, 32'h12D4,   0, 0, 1, 32'h12D4, 32'h1234, 32'h1238, 1));
    tv.push_back(mk(1, 32'h10, 1, 0, 0,     1, 1, 0, 32'h12D4, 32'h1234, 32'h10, 1));
    // Branch in the same cycle as the request handshake at 0x10
    tv.push_back(mk(1, 32'h5674, 1, 0, 0,   0, 0, 0, 32'h12D4, 32'h1234, 32'h5674, 1));
    tv.push_back(mk(0, 0, 1, 1, 32'hB0,     0, 1, 0, 32'h12D4, 32'h1234, 32'h5674, 2));
    tv.push_back(mk(0, 0, 1, 0, 0,          0, 0, 0, 32'h12D4, 32'h1234, 32'h5678, 2));
    tv.push_back(mk(0, 0, 1, 1, 32'h5714,   0, 0, 1, 32'h5714, 32'h5674, 32'h5678, 2));
    tv.push_back(mk(0, 0, 1, 0, 0,          1, 1, 0, 32'h5714, 32'h5674, 32'h5678, 2));
    tv.push_back(mk(0, 0, 1, 0, 0,          0, 0, 0, 32'h5714, 32'h5674, 32'h567C, 2));
    tv.push_back(mk(0, 0, 1, 1, 32'h5718,   0, 0, 1, 32'h5718, 32'h5678, 32'h567C, 2));
    tv.push_back(mk(0, 0, 1, 0, 0,          1, 1, 0, 32'h5718, 32'h5678, 32'h567C, 2));
    tv.push_back(mk(0, 0, 1, 0, 0,          0, 0, 0, 32'h5718, 32'h5678, 32'h5680, 2));
    // Branch coinciding with a response in WAIT; target low bits forced to zero
    tv.push_back(mk(1, 32'hFFFF_FFFF, 0, 1, 32'h1111, 0, 1, 0, 32'h5718, 32'h5678, 32'hFFFF_FFFC, 3));
    // Stray response outside WAIT is ignored
    tv.push_back(mk(0, 0, 0, 1, 32'h2222,   0, 1, 0, 32'h5718, 32'h5678, 32'hFFFF_FFFC, 3));
    // PC wraps to zero
    tv.push_back(mk(0, 0, 1, 0, 0,          0, 0, 0, 32'h5718, 32'h5678, 32'h0, 3));
    tv.push_back(mk(0, 0, 1, 1, 32'h9C,     0, 0, 1, 32'h9C, 32'hFFFF_FFFC, 32'h0, 3));
    tv.push_back(mk(0, 0, 1, 1, 32'h3333,   0, 0, 1, 32'h9C, 32'hFFFF_FFFC, 32'h0, 3));
    tv.push_back(mk(0, 0, 0, 0, 0,          1, 1, 0, 32'h9C, 32'hFFFF_FFFC, 32'h0, 3));
    tv.push_back(mk(0, 0, 1, 0, 0,          0, 0, 0, 32'h9C, 32'hFFFF_FFFC, 32'h4, 3));
    // Squash counter saturates at all-ones
    tv.push_back(mk(1, 32'h40, 0, 0, 0,     0, 0, 0, 32'h9C, 32'hFFFF_FFFC, 32'h40, 3));
    tv.push_back(mk(0, 0, 0, 1, 32'h4444,   0, 1, 0, 32'h9C, 32'hFFFF_FFFC, 32'h40, 3));
    tv.push_back(mk(0, 0, 1, 0, 0,          0, 0, 0, 32'h9C, 32'hFFFF_FFFC, 32'h44, 3));
    // Leave a pending squash in WAIT for the reset test
    tv.push_back(mk(1, 32'h81, 0, 0, 0,     0, 0, 0, 32'h9C, 32'hFFFF_FFFC, 32'h80, 3));

    repeat (2) @(posedge clock);
    #1;
    check(zero, "reset_state");
    reset = 1'b0;

    for (int i = 0; i < tv.size(); i++)
      run(tv[i], $sformatf("vec%0d", i));

    // Asynchronous reset in the middle of WAIT with squash pending
    drive(zero);
    #2;
    reset = 1'b1;
    #1;
    check(zero, "async_reset");
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Squash flag must be clear: this response is delivered
    run(mk(0, 0, 1, 0, 0,        0, 1, 0, 0,        0, 32'h0, 0), "post_reset_req");
    run(mk(0, 0, 1, 0, 0,        0, 0, 0, 0,        0, 32'h4, 0), "post_reset_accept");
    run(mk(0, 0, 1, 1, 32'h5555, 0, 0, 1, 32'h5555, 0, 32'h4, 0), "post_reset_deliver");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controls the instruction-fetch front end: owns the fetch program counter, issues one request at a time to instruction memory over a valid/ready handshake, and holds the returned instruction in a single output register for decode.
- Applies branch redirects, including squashing an in-flight fetch.
- Sits between the PC logic and decode in the single-cycle-derived core, replacing the free-running PC+4 update with a sequenced fetch.

Parameters:
- XLEN, 32, address/instruction width.
- RESET_PC, 32'h0000_0000, PC value loaded by reset.
- CNT_W, 16, width of the saturating squash counter.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- branch  input  1  redirect pulse from execute; valid for one cycle.
- target_PC  input  XLEN  redirect address; bits [1:0] are ignored and forced to 0.
- imem_req_valid  output  1  fetch request valid.
- imem_req_addr  output  XLEN  fetch address; equals PC.
- imem_req_ready  input  1  memory accepts request.
- imem_resp_valid  input  1  response data valid.
- imem_resp_data  input  XLEN  fetched instruction.
- inst_valid  output  1  output register holds an instruction.
- inst_data  output  XLEN  held instruction.
- inst_PC  output  XLEN  address of held instruction.
- inst_ready  input  1  decode consumes instruction.
- PC  output  XLEN  next fetch address register.
- squash_count  output  CNT_W  number of dropped responses; saturates at all-ones.

Behaviour:
- Reset (async, any time, including mid-transaction):
  - state=IDLE, PC=RESET_PC.
  - inst_valid=0, inst_data=0, inst_PC=0.
  - squash flag=0, squash_count=0.
  - imem_req_valid=0 while reset is asserted.
- States: IDLE, REQ, WAIT, FULL.
  - imem_req_valid = (state==REQ). It is combinational from state and does not depend on imem_req_ready.
  - IDLE -> REQ unconditionally on the first clock after reset deasserts.
  - REQ:
    - On imem_req_ready: req_pc <= PC, PC <= PC+4, go to WAIT.
    - Otherwise hold; request and address stay stable.
  - WAIT, on imem_resp_valid:
    - If squash=1: drop the data, clear squash, increment squash_count (saturating), go to REQ.
    - Else: inst_data <= imem_resp_data, inst_PC <= req_pc, inst_valid <= 1, go to FULL.
  - FULL:
    - On inst_valid & inst_ready: inst_valid <= 0, go to REQ.
    - Otherwise hold; inst_data and inst_PC are stable.
- Latency: with zero-wait memory (ready=1, response the cycle after acceptance), one instruction is delivered per 3 cycles (REQ, WAIT, FULL). inst_valid rises the cycle after imem_resp_valid.
- Branch has the highest priority and is applied on the clock edge where branch=1:
  - PC <= {target_PC[XLEN-1:2],2'b00}. This overrides PC+4 even if a request handshake occurs in the same cycle.
  - inst_valid <= 0. The held instruction is discarded and is not consumed even if inst_ready=1 that cycle.
  - State and squash by current state:
    - IDLE: state unchanged.
    - REQ without handshake: stay in REQ, now fetching target.
    - REQ with handshake: go to WAIT, squash <= 1.
    - WAIT without response: squash <= 1.
    - WAIT with response the same cycle: drop the response, count it as a squash, go to REQ.
    - FULL: go to REQ.
- PC arithmetic is modulo 2^XLEN: 32'hFFFF_FFFC + 4 wraps to 0.
- Protocol misuse: imem_resp_valid outside WAIT is ignored and not counted.

Test Plan:
- Reset then release with ready=1 and 1-cycle memory returning 32'hA0+addr, inst_ready=1 -> requests to 0x0, 0x4, 0x8; inst_PC sequence 0x0, 0x4, 0x8; inst_data 0xA0, 0xA4, 0xA8; PC=0xC after the third acceptance.
- Hold inst_ready=0 with an instruction held for 5 cycles -> imem_req_valid stays 0, inst_data/inst_PC stable, PC unchanged; release inst_ready -> the next request issues the following cycle.
- Pulse branch with target_PC=32'h1236 while in WAIT, response arriving 2 cycles later -> response dropped, inst_valid stays 0, squash_count=1, next request address 0x1234, delivered inst_PC=0x1234.
- Branch to 0x5674 in the same cycle as a REQ handshake at 0x10 -> PC=0x5674 (not 0x14), the 0x10 response is squashed, next delivered inst_PC=0x5674, then 0x5678.
- Branch while in FULL holding inst_PC=0x8 with inst_ready=1 -> 0x8 is not delivered, inst_valid=0 the next cycle, the fetch at the target starts in REQ.
- Set PC to 32'hFFFF_FFFC via branch, let it fetch, then assert reset during WAIT -> after the fetch PC wraps to 0x0; reset asynchronously clears inst_valid, squash and squash_count and sets PC=RESET_PC.
